// File: rtl/control_seq.sv
// control_seq: registered valid/ready MIPS decode controller
// with a sequenced multi-cycle multiply and illegal-op counting.
module control_seq #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 32,
  parameter int ERR_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  output logic               ctrl_valid,
  input  logic               ctrl_ready,
  output logic [3*REG_W+7:0] ctrl,
  output logic               illegal,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam int CW = 3*REG_W+8;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             rf_wr;
    logic             mux_writeback;
    logic             mem_wr;
    logic             mux_alu_out;
    logic             start;
    logic [1:0]       alu_op;
    logic             mux_alu_in;
  } word_t;

  typedef enum logic [1:0] {
    IDLE, MUL_ISSUE, MUL_BUSY, MUL_WB
  } state_e;

  localparam word_t NOP_W = word_t'(CW'(16));

  localparam logic [5:0] OP_R  = 6'd12;
  localparam logic [5:0] OP_LW = 6'd13;
  localparam logic [5:0] OP_SW = 6'd14;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_MUL = 6'd50;

  state_e           state_q, state_d;
  word_t            ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [5:0]       opc, fn;
  logic [REG_W-1:0] f_rs, f_rt, f_rd;
  word_t            dec_w;
  logic             dec_mul, dec_ill;
  logic             xfer, accept;
  logic             unused_bits;

  assign opc  = instr[31:26];
  assign fn   = instr[5:0];
  assign f_rs = REG_W'(instr[25:21]);
  assign f_rt = REG_W'(instr[20:16]);
  assign f_rd = REG_W'(instr[15:11]);
  assign unused_bits = ^instr[10:6];

  assign xfer   = valid_q && ctrl_ready;
  assign accept = instr_valid && instr_ready;

  // Decode the incoming instruction into a control word
  always_comb begin
    dec_w   = NOP_W;
    dec_mul = 1'b0;
    dec_ill = 1'b0;
    unique case (1'b1)
      (opc == OP_LW) || (opc == OP_SW): begin
        dec_w.rs            = f_rs;
        dec_w.rt            = f_rt;
        dec_w.rd            = f_rt;
        dec_w.rf_wr         = (opc == OP_LW);
        dec_w.mux_writeback = 1'b1;
        dec_w.mem_wr        = (opc == OP_SW);
        dec_w.mux_alu_in    = 1'b1;
      end
      opc == OP_R: begin
        dec_w.rs    = f_rs;
        dec_w.rt    = f_rt;
        dec_w.rd    = f_rd;
        dec_w.rf_wr = 1'b1;
        case (fn)
          FN_ADD: dec_w.alu_op = 2'd0;
          FN_SUB: dec_w.alu_op = 2'd1;
          FN_AND: dec_w.alu_op = 2'd2;
          FN_OR:  dec_w.alu_op = 2'd3;
          FN_MUL: begin
            dec_w.rf_wr       = 1'b0;
            dec_w.mux_alu_out = 1'b0;
            dec_w.start       = 1'b1;
            dec_mul           = 1'b1;
          end
          default: begin
            dec_w   = NOP_W;
            dec_ill = 1'b1;
          end
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Next-state: handshake, multiply sequencing, error count
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ill_d   = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ctrl_d  = dec_w;
          valid_d = 1'b1;
          ill_d   = dec_ill;
          if (dec_ill && !(&err_q))
            err_d = err_q + 1'b1;
          if (dec_mul)
            state_d = MUL_ISSUE;
        end else if (xfer) begin
          valid_d = 1'b0;
        end
      end
      MUL_ISSUE: begin
        if (xfer) begin
          state_d = MUL_BUSY;
          valid_d = 1'b0;
          cnt_d   = 8'(MUL_LAT - 1);
        end
      end
      MUL_BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d      = MUL_WB;
          ctrl_d.rf_wr = 1'b1;
          ctrl_d.start = 1'b0;
          valid_d      = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      MUL_WB: begin
        if (xfer) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready only in IDLE when the output slot frees
  always_comb begin
    instr_ready = (state_q == IDLE) && (!valid_q || ctrl_ready);
    ctrl_valid  = valid_q;
    ctrl        = ctrl_q;
    illegal     = ill_q;
    err_cnt     = err_q;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= NOP_W;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
      ill_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/control_seq.md
# control_seq

Registered, handshaked instruction-decode controller for the MIPS datapath, replacing the purely combinational decoder. It accepts one 32-bit instruction per cycle over a valid/ready interface and emits a registered control word to the datapath. Multiply is sequenced as a multi-cycle operation: a start word, a counted busy window, then a separate writeback word. Illegal instructions are flagged and counted instead of holding stale controls.

## Interface
- REG_W, 5: register-index width in the control word; instruction fields (5 bits) are zero-extended to REG_W.
- MUL_LAT, 32: multiplier busy cycles after the start word transfers; legal range 1..255.
- ERR_W, 8: illegal-instruction counter width.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  instr holds an instruction.
- instr  in  32  instruction word.
- instr_ready  out  1  combinational; accept when instr_valid && instr_ready.
- ctrl_valid  out  1  ctrl holds a word to consume.
- ctrl_ready  in  1  datapath consumes the word when ctrl_valid && ctrl_ready.
- ctrl  out  3*REG_W+8  {rs, rt, rd, rf_wr, mux_writeback, mem_wr, mux_alu_out, start, alu_op[1:0], mux_alu_in}.
- illegal  out  1  one-cycle pulse, the cycle after an illegal instruction is accepted.
- err_cnt  out  ERR_W  saturating illegal count.

## Operation
- Fields: opcode=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- NOP word: all fields 0 except mux_alu_out=1.
- opcode 13 (LW): rd=rt, rf_wr=1, mux_writeback=1, mem_wr=0, mux_alu_in=1, mux_alu_out=1, start=0, alu_op=0.
- opcode 14 (SW): as LW but rf_wr=0, mem_wr=1.
- opcode 12 (R-type): rd=instr rd, rf_wr=1, mux_writeback=0, mux_alu_in=0, mux_alu_out=1, start=0; funct 32→alu_op 0, 34→1, 36→2, 37→3.
- funct 50 (MUL): start word = rs, rt, rd, rf_wr=0, mux_alu_out=0, start=1, all else 0; writeback word = same rs/rt/rd, rf_wr=1, mux_alu_out=0, start=0, all else 0.
- Any other opcode, or opcode 12 with unlisted funct: illegal; NOP word with rs=rt=rd=0 issued, illegal pulses, err_cnt increments, saturating at all-ones.
- States: IDLE, MUL_ISSUE, MUL_BUSY, MUL_WB.
- IDLE: instr_ready = !ctrl_valid || ctrl_ready. On accept, load decoded word, ctrl_valid=1; MUL goes to MUL_ISSUE, others stay IDLE. No accept while ctrl_valid && !ctrl_ready: word held stable.
- MUL_ISSUE: instr_ready=0; start word held until transfer; on transfer → MUL_BUSY, counter=MUL_LAT-1, ctrl_valid=0.
- MUL_BUSY: instr_ready=0, ctrl_valid=0; counter decrements; at counter==0 → MUL_WB with writeback word loaded, ctrl_valid=1.
- MUL_WB: instr_ready=0; on transfer → IDLE, ctrl_valid=0.
- start=1 appears on exactly one transferred word per MUL.

## Timing
- Reset (rst_n low at an edge): state IDLE, ctrl_valid=0, ctrl=NOP, illegal=0, err_cnt=0, counter=0. instr_ready is 1 the cycle after reset releases.
- Reset mid-MUL discards any pending start/writeback word; no writeback word is issued.
- Non-MUL latency: accepted at edge T → ctrl_valid at T+1. Throughput 1 word/cycle with ctrl_ready held high.
- MUL with ctrl_ready high: accepted at T, start word valid at T+1 and transferred at T+1. Busy during T+2..T+1+MUL_LAT. Writeback word valid at T+2+MUL_LAT. Next instruction is accepted no earlier than the writeback transfer cycle +1.
- ctrl_ready low stalls any state holding a word. MUL_BUSY counting is independent of ctrl_ready.
- illegal is high only in the cycle the NOP word first becomes valid.

## Test plan
- Reset, then LW 0x35280004 with ctrl_ready=1 → next cycle ctrl_valid=1, rs=9, rt=8, rd=8, rf_wr=1, mux_writeback=1, mux_alu_in=1, mem_wr=0.
- Back-to-back ADD/SUB/AND/OR (funct 32/34/36/37) with ctrl_ready=1 → four consecutive words, alu_op 0,1,2,3; instr_ready constantly 1.
- MUL (opcode 12, funct 50), MUL_LAT=4, ctrl_ready=1 → start word at T+1 (start=1, rf_wr=0, mux_alu_out=0); instr_ready=0 through T+6; writeback word (rf_wr=1, start=0) at T+6.
- SW with ctrl_ready low for 3 cycles → ctrl stable and instr_ready=0 for those cycles; single transfer when ctrl_ready rises.
- Opcode 63, then opcode 12/funct 7, with ERR_W=2, repeated 5 times → NOP words, illegal pulses each time, err_cnt 1,2,3,3,3.
- rst_n low during MUL_BUSY → ctrl_valid=0, err_cnt=0, no writeback word; a subsequent ADD is accepted the cycle after release.
